// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and holds one instruction for decode until it is consumed or redirected.
module fetch_unit #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [AWIDTH-1:0] branch_target,
    output logic [DWIDTH-1:0] fetch_instr,
    output logic              fetch_valid,
    output logic [AWIDTH-1:0] fetch_pc,
    output logic [31:0]       instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [AWIDTH-1:0] PC_RST = AWIDTH'(RESET_PC);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] pc_pending_q, pc_pending_d;
    logic              flush_q, flush_d;
    logic              imem_req_q, imem_req_d;
    logic [DWIDTH-1:0] fetch_instr_q, fetch_instr_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]       instr_count_q, instr_count_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_pending_d  = pc_pending_q;
        flush_d       = flush_q;
        fetch_instr_d = fetch_instr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        instr_count_d = instr_count_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (branch_en) begin
                    pc_d = branch_target;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (flush_q) begin
                        // Data belongs to a superseded path; refetch the newest target.
                        pc_d    = branch_en ? branch_target : pc_pending_q;
                        flush_d = 1'b0;
                    end else if (branch_en) begin
                        pc_d = branch_target;
                    end else begin
                        fetch_instr_d = imem_rdata;
                        fetch_pc_d    = pc_q;
                        fetch_valid_d = 1'b1;
                        pc_d          = pc_q + AWIDTH'(1);
                        state_d       = S_FULL;
                    end
                end else if (branch_en) begin
                    flush_d      = 1'b1;
                    pc_pending_d = branch_target;
                end
            end
            S_FULL: begin
                if (branch_en) begin
                    fetch_valid_d = 1'b0;
                    pc_d          = branch_target;
                    state_d       = S_FETCH;
                end else if (!stall) begin
                    fetch_valid_d = 1'b0;
                    instr_count_d = instr_count_q + 32'd1;
                    state_d       = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= PC_RST;
            pc_pending_q  <= PC_RST;
            flush_q       <= 1'b0;
            imem_req_q    <= 1'b0;
            fetch_instr_q <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= PC_RST;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_pending_q  <= pc_pending_d;
            flush_q       <= flush_d;
            imem_req_q    <= imem_req_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level reference model.
module tb_fetch_unit;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          stall;
    logic          branch_en;
    logic [AW-1:0] branch_target;
    logic [DW-1:0] fetch_instr;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic [31:0]   instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(.DWIDTH(DW), .AWIDTH(AW), .RESET_PC(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .fetch_instr   (fetch_instr),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    // Reference model: a started flag, a held-instruction flag and a
    // queued redirect describe the whole fetch behaviour.
    bit          m_started;
    bit          m_have;
    bit          m_redir;
    int unsigned m_redir_t;
    int unsigned m_pc;
    logic [31:0] m_instr;
    int unsigned m_fpc;
    longint      m_count;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 0;
        m_have    = 0;
        m_redir   = 0;
        m_redir_t = 0;
        m_pc      = 0;
        m_instr   = '0;
        m_fpc     = 0;
        m_count   = 0;
    endtask

    task automatic model_step();
        int unsigned tgt;
        tgt = branch_target;
        if (rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
            if (branch_en) m_pc = tgt;
        end else if (m_have) begin
            if (branch_en) begin
                m_have = 0;
                m_pc   = tgt;
            end else if (!stall) begin
                m_have  = 0;
                m_count = (m_count + 1) % 64'h1_0000_0000;
            end
        end else if (imem_ack) begin
            if (m_redir || branch_en) begin
                m_pc    = branch_en ? tgt : m_redir_t;
                m_redir = 0;
            end else begin
                m_instr = imem_rdata;
                m_fpc   = m_pc;
                m_have  = 1;
                m_pc    = (m_pc + 1) % (1 << AW);
            end
        end else if (branch_en) begin
            m_redir   = 1;
            m_redir_t = tgt;
        end
    endtask

    task automatic compare_all();
        check("imem_req", 32'(imem_req), 32'(m_started && !m_have));
        check("imem_addr", 32'(imem_addr), m_pc);
        check("fetch_valid", 32'(fetch_valid), 32'(m_have));
        check("fetch_instr", fetch_instr, m_instr);
        check("fetch_pc", 32'(fetch_pc), m_fpc);
        check("instr_count", instr_count, 32'(m_count));
    endtask

    function automatic logic [AW-1:0] pick_target();
        unique case ($urandom_range(0, 4))
            0: return AW'(0);
            1: return AW'(1023);
            2: return AW'(10'h200);
            3: return AW'(1022);
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic cycle(input int p_rst, input int p_br, input int p_stall,
                         input int p_ack);
        @(negedge clk);
        compare_all();
        rst           = ($urandom_range(0, 999) < p_rst);
        branch_en     = ($urandom_range(0, 99) < p_br);
        branch_target = pick_target();
        stall         = ($urandom_range(0, 99) < p_stall);
        imem_ack      = ($urandom_range(0, 99) < p_ack);
        imem_rdata    = $urandom;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        branch_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        @(posedge clk);
        model_step();
        // Quiet streaming: frequent acks, no stalls or branches.
        for (int i = 0; i < 60; i++) cycle(0, 0, 0, 90);
        // Heavy stalling with occasional redirects.
        for (int i = 0; i < 400; i++) cycle(0, 8, 70, 50);
        // Slow memory so redirects pile up during a fetch.
        for (int i = 0; i < 800; i++) cycle(0, 20, 30, 15);
        // Everything including mid-flight resets.
        for (int i = 0; i < 3000; i++) cycle(15, 12, 40, 40);
        @(negedge clk);
        compare_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
